// File: rtl/extrema_pkg.sv
// Shared types for the frame extrema tracker and its comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package extrema_pkg;

  localparam int SAMPLE_W = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } ext_state_t;

endpackage

// File: rtl/frame_extrema_tracker_cmp.sv
// Purpose: 4-bit unsigned magnitude comparator (a vs b), one-hot gt/eq/lt result.
// Latency: combinational, zero cycles.
// Backpressure: none, purely combinational.
// Ports: a, b (samples in); agtb, aeqb, altb (exactly one is high).
module frame_extrema_tracker_cmp
  import extrema_pkg::*;
(
  input  sample_t a,
  input  sample_t b,
  output logic    agtb,
  output logic    aeqb,
  output logic    altb
);

  assign agtb = (a > b);
  assign aeqb = (a == b);
  assign altb = (a < b);

endmodule

// File: rtl/frame_extrema_tracker.sv
// Purpose: per-frame running max/min, sample count and all-equal flag over a sample stream.
// Latency: result valid the cycle after the in_last beat; 1 sample/cycle while accumulating.
// Backpressure: in_ready low while a result waits in DONE; result held until out_ready.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready/in_data/in_last  sample stream
//   out_valid/out_ready                result handshake
//   out_max/out_min/out_count          frame extrema and saturating sample count
//   out_all_eq/out_ovf                 all samples equal / count saturated
module frame_extrema_tracker
  import extrema_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_all_eq,
  output logic             out_ovf
);

  // The comparator is hard 4-bit; any other width is a build error.
  if (WIDTH != SAMPLE_W) begin : g_width_chk
    $error("frame_extrema_tracker: WIDTH must equal SAMPLE_W (4)");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ext_state_t       state;
  sample_t          max_r;
  sample_t          min_r;
  logic [CNT_W-1:0] count_r;
  logic             all_eq_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic max_gt, max_eq, max_lt;
  logic min_gt, min_eq, min_lt;
  logic beat;

  // Comparator A: new sample against running max.
  frame_extrema_tracker_cmp u_cmp_max (
    .a    (in_data),
    .b    (max_r),
    .agtb (max_gt),
    .aeqb (max_eq),
    .altb (max_lt)
  );

  // Comparator B: new sample against running min.
  frame_extrema_tracker_cmp u_cmp_min (
    .a    (in_data),
    .b    (min_r),
    .agtb (min_gt),
    .aeqb (min_eq),
    .altb (min_lt)
  );

  // Gated by rst_n so the source sees no ready while reset is held,
  // even though the state register already reads IDLE.
  assign in_ready = rst_n && (state != DONE);
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      max_r       <= '0;
      min_r       <= '0;
      count_r     <= '0;
      all_eq_r    <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            max_r       <= in_data;
            min_r       <= in_data;
            count_r     <= {{(CNT_W-1){1'b0}}, 1'b1};
            all_eq_r    <= 1'b1;
            ovf_r       <= 1'b0;
            out_valid_r <= in_last;
            state       <= in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            if (max_gt) max_r <= in_data;
            if (min_lt) min_r <= in_data;
            // While all_eq holds, max==min==first sample, so any
            // inequality on either side means this sample differs.
            if (!max_eq || !min_eq) all_eq_r <= 1'b0;
            if (count_r == CNT_MAX) ovf_r   <= 1'b1;
            else                    count_r <= count_r + 1'b1;
            if (in_last) begin
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Result registers double as the accumulators; they only change on
  // accepted beats, so they are stable throughout DONE.
  assign out_valid  = out_valid_r;
  assign out_max    = max_r;
  assign out_min    = min_r;
  assign out_count  = count_r;
  assign out_all_eq = all_eq_r;
  assign out_ovf    = ovf_r;

  logic unused_cmp;
  assign unused_cmp = max_lt ^ min_gt;

endmodule

// File: tb/tb_frame_extrema_tracker.sv
module tb_frame_extrema_tracker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_all_eq,  out_ovf;
  logic [3:0] out_max,   out_min;
  logic [7:0] out_count;

  logic       s_in_ready, s_out_valid, s_out_all_eq, s_out_ovf;
  logic [3:0] s_out_max,  s_out_min;
  logic [2:0] s_out_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] fbuf [0:15];

  frame_extrema_tracker #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_count(out_count),
    .out_all_eq(out_all_eq), .out_ovf(out_ovf)
  );

  frame_extrema_tracker #(.WIDTH(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_max(s_out_max), .out_min(s_out_min), .out_count(s_out_count),
    .out_all_eq(s_out_all_eq), .out_ovf(s_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample starting at a negedge, optionally after idle cycles;
  // returns at the negedge after it was accepted.
  task automatic beat(input logic [3:0] d, input logic l, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int gapmax);
    for (int i = 0; i < n; i++)
      beat(fbuf[i], (i == n - 1), $urandom_range(0, gapmax));
  endtask

  task automatic check_result(input string tag, input logic [3:0] mx, input logic [3:0] mn,
                              input logic [7:0] cnt, input logic aeq, input logic ovf);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_max"},   out_max,   mx);
    check({tag, "_min"},   out_min,   mn);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_alleq"}, out_all_eq, aeq);
    check({tag, "_ovf"},   out_ovf,   ovf);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid_low", out_valid, 0);
    check("release_ready_high", in_ready, 1);
  endtask

  initial begin
    logic [3:0] mx, mn;
    logic       aeq;
    int         n;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_max", out_max, 0);
    check("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Reset mid-ACCUM after 3, 9
    beat(4'd3, 1'b0, 0);
    beat(4'd9, 1'b0, 0);
    check("accum_max_partial", out_max, 9);
    rst_n = 1'b0;
    #1;
    check("midacc_rst_out_valid", out_valid, 0);
    check("midacc_rst_in_ready", in_ready, 0);
    check("midacc_rst_count", out_count, 0);
    @(negedge clk);
    check("midacc_rst_in_ready_hold", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    beat(4'd5, 1'b1, 0);
    check_result("one_sample", 4'd5, 4'd5, 8'd1, 1'b1, 1'b0);
    release_result();

    // Basic frame: check valid is still low before the last beat lands
    beat(4'd7, 1'b0, 0);
    beat(4'd2, 1'b0, 0);
    beat(4'd12, 1'b0, 0);
    check("basic_valid_early", out_valid, 0);
    beat(4'd4, 1'b1, 0);
    check_result("basic", 4'd12, 4'd2, 8'd4, 1'b0, 1'b0);
    release_result();

    // Equal frame, then reset while holding the result in DONE
    fbuf[0] = 4'd6; fbuf[1] = 4'd6; fbuf[2] = 4'd6;
    send_frame(3, 0);
    check_result("ties", 4'd6, 4'd6, 8'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", out_valid, 0);
    check("done_rst_out_max", out_max, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Extreme values
    fbuf[0] = 4'd0; fbuf[1] = 4'd15;
    send_frame(2, 0);
    check_result("bounds", 4'd15, 4'd0, 8'd2, 1'b0, 1'b0);
    release_result();

    // New max in the last sample, new min late
    fbuf[0] = 4'd8; fbuf[1] = 4'd8; fbuf[2] = 4'd1; fbuf[3] = 4'd14;
    send_frame(4, 0);
    check_result("last_is_max", 4'd14, 4'd1, 8'd4, 1'b0, 1'b0);
    release_result();

    // Backpressure with the next sample already waiting
    fbuf[0] = 4'd11; fbuf[1] = 4'd1;
    send_frame(2, 0);
    check_result("bp", 4'd11, 4'd1, 8'd2, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 4'd8; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_max_stable", out_max, 11);
      check("bp_min_stable", out_min, 1);
      check("bp_count_stable", out_count, 2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_result("bp_next", 4'd8, 4'd8, 8'd1, 1'b1, 1'b0);
    release_result();

    // Saturation: nine 1s; CNT_W=3 instance saturates at 7
    for (int i = 0; i < 9; i++) fbuf[i] = 4'd1;
    send_frame(9, 0);
    check_result("nosat", 4'd1, 4'd1, 8'd9, 1'b1, 1'b0);
    check("sat_valid", s_out_valid, 1);
    check("sat_count", s_out_count, 7);
    check("sat_ovf", s_out_ovf, 1);
    check("sat_alleq", s_out_all_eq, 1);
    check("sat_max", s_out_max, 1);
    release_result();
    check("sat_release", s_out_valid, 0);

    // Random frames with valid gaps and consumer delay against a model
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) fbuf[i] = 4'($urandom_range(0, 15));
      mx = fbuf[0]; mn = fbuf[0]; aeq = 1'b1;
      for (int i = 1; i < n; i++) begin
        if (fbuf[i] > mx) mx = fbuf[i];
        if (fbuf[i] < mn) mn = fbuf[i];
        if (fbuf[i] != fbuf[0]) aeq = 1'b0;
      end
      send_frame(n, 2);
      check_result("rand", mx, mn, 8'(n), aeq, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rand_hold_max", out_max, mx);
      end
      release_result();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
